// File: rtl/rgb2ycbcr_pkg.sv
// Shared types and Q8 coefficient tables for the RGB to YCbCr pipeline.
package rgb2ycbcr_pkg;

  typedef enum logic {
    MODE_601 = 1'b0,
    MODE_709 = 1'b1
  } mode_e;

  typedef logic signed [8:0] coef_t;

  localparam int FRAC = 8;

  // Rows are Y, Cb, Cr; columns are R, G, B weights.
  localparam coef_t C601 [3][3] = '{
    '{ 9'sd77,   9'sd150,  9'sd29 },
    '{-9'sd43,  -9'sd85,   9'sd128},
    '{ 9'sd128, -9'sd107, -9'sd21 }
  };

  localparam coef_t C709 [3][3] = '{
    '{ 9'sd54,   9'sd183,  9'sd19 },
    '{-9'sd29,  -9'sd99,   9'sd128},
    '{ 9'sd128, -9'sd116, -9'sd12 }
  };

  function automatic coef_t coef(
    input mode_e m,
    input int    ch,
    input int    k
  );
    return (m == MODE_709) ? C709[ch][k] : C601[ch][k];
  endfunction

endpackage

// File: rtl/ycc_dot3.sv
// One output channel: registered products, offset/round sum,
// then shift, saturate and DE gate.
module ycc_dot3
  import rgb2ycbcr_pkg::*;
#(
  parameter int DW     = 8,
  parameter bit OFS_EN = 1'b0
) (
  input  logic          clk,
  input  logic          rst,
  input  coef_t         c0,
  input  coef_t         c1,
  input  coef_t         c2,
  input  logic [DW-1:0] r,
  input  logic [DW-1:0] g,
  input  logic [DW-1:0] b,
  input  logic          gate,
  output logic [DW-1:0] q
);

  localparam int AW   = DW + 11;
  localparam int OFSI = OFS_EN ? (1 << (DW - 1 + FRAC)) : 0;

  localparam logic signed [AW-1:0] OFS  = AW'(OFSI);
  localparam logic signed [AW-1:0] RND  = AW'(1 << (FRAC - 1));
  localparam logic signed [AW-1:0] MAXV = AW'((1 << DW) - 1);

  logic signed [AW-1:0] rx, gx, bx;
  logic signed [AW-1:0] k0, k1, k2;
  logic signed [AW-1:0] p0, p1, p2;
  logic signed [AW-1:0] s, sh;
  logic        [DW-1:0] sat;

  assign rx = AW'({1'b0, r});
  assign gx = AW'({1'b0, g});
  assign bx = AW'({1'b0, b});

  assign k0 = AW'(c0);
  assign k1 = AW'(c1);
  assign k2 = AW'(c2);

  assign sh = s >>> FRAC;

  always_comb begin
    sat = sh[DW-1:0];
    if (sh[AW-1]) begin
      sat = '0;
    end else if (sh > MAXV) begin
      sat = '1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p0 <= '0;
      p1 <= '0;
      p2 <= '0;
      s  <= '0;
      q  <= '0;
    end else begin
      p0 <= rx * k0;
      p1 <= gx * k1;
      p2 <= bx * k2;
      s  <= p0 + p1 + p2 + OFS + RND;
      q  <= gate ? sat : '0;
    end
  end

endmodule

// File: rtl/rgb2ycbcr_pipe.sv
// Three-cycle RGB to YCbCr converter with per-frame mode latch
// and matching sync/DE delay lines.
module rgb2ycbcr_pipe
  import rgb2ycbcr_pkg::*;
#(
  parameter int DW       = 8,
  parameter bit MODE_RST = 1'b0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          mode_sel,
  input  logic          pre_frame_vsync,
  input  logic          pre_frame_hsync,
  input  logic          pre_frame_de,
  input  logic [DW-1:0] rgb_r,
  input  logic [DW-1:0] rgb_g,
  input  logic [DW-1:0] rgb_b,
  output logic          post_frame_vsync,
  output logic          post_frame_hsync,
  output logic          post_frame_de,
  output logic [DW-1:0] img_y,
  output logic [DW-1:0] img_cb,
  output logic [DW-1:0] img_cr,
  output logic          mode_act
);

  mode_e      mode_q;
  logic [2:0] vs_d, hs_d, de_d;

  // vs_d[0] doubles as the previous-vsync sample for edge detect.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q <= mode_e'(MODE_RST);
      vs_d   <= '0;
      hs_d   <= '0;
      de_d   <= '0;
    end else begin
      if (pre_frame_vsync && !vs_d[0]) begin
        mode_q <= mode_e'(mode_sel);
      end
      vs_d <= {vs_d[1:0], pre_frame_vsync};
      hs_d <= {hs_d[1:0], pre_frame_hsync};
      de_d <= {de_d[1:0], pre_frame_de};
    end
  end

  assign post_frame_vsync = vs_d[2];
  assign post_frame_hsync = hs_d[2];
  assign post_frame_de    = de_d[2];
  assign mode_act         = mode_q;

  ycc_dot3 #(.DW(DW), .OFS_EN(1'b0)) u_y (
    .clk  (clk),
    .rst  (rst),
    .c0   (coef(mode_q, 0, 0)),
    .c1   (coef(mode_q, 0, 1)),
    .c2   (coef(mode_q, 0, 2)),
    .r    (rgb_r),
    .g    (rgb_g),
    .b    (rgb_b),
    .gate (de_d[1]),
    .q    (img_y)
  );

  ycc_dot3 #(.DW(DW), .OFS_EN(1'b1)) u_cb (
    .clk  (clk),
    .rst  (rst),
    .c0   (coef(mode_q, 1, 0)),
    .c1   (coef(mode_q, 1, 1)),
    .c2   (coef(mode_q, 1, 2)),
    .r    (rgb_r),
    .g    (rgb_g),
    .b    (rgb_b),
    .gate (de_d[1]),
    .q    (img_cb)
  );

  ycc_dot3 #(.DW(DW), .OFS_EN(1'b1)) u_cr (
    .clk  (clk),
    .rst  (rst),
    .c0   (coef(mode_q, 2, 0)),
    .c1   (coef(mode_q, 2, 1)),
    .c2   (coef(mode_q, 2, 2)),
    .r    (rgb_r),
    .g    (rgb_g),
    .b    (rgb_b),
    .gate (de_d[1]),
    .q    (img_cr)
  );

endmodule

// File: doc/rgb2ycbcr_pipe.md
# rgb2ycbcr_pipe

Registered, parametrised RGB-to-YCbCr converter for the video processing chain, sitting between the RGB888/RGB101010 capture path and the skin-detect / binarisation stages. It generalises the combinational converter: configurable component width, run-time selectable BT.601/BT.709 coefficient sets latched per frame, round-to-nearest with saturation, and a fixed 3-cycle pipeline with sync/DE signals delayed to match.

## Interface
Parameters:
- DW, 8: component width in bits for inputs and outputs (8..12).
- MODE_RST, 0: coefficient mode loaded at reset (0 = BT.601 full range, 1 = BT.709 full range).

Ports:
- clk  in  1  pixel clock; single clock domain.
- rst  in  1  reset, asynchronous, active-high.
- mode_sel  in  1  requested coefficient mode; sampled only at frame start.
- pre_frame_vsync  in  1  input vsync.
- pre_frame_hsync  in  1  input hsync.
- pre_frame_de  in  1  input data enable.
- rgb_r / rgb_g / rgb_b  in  DW  input components, unsigned.
- post_frame_vsync  out  1  vsync delayed 3 cycles.
- post_frame_hsync  out  1  hsync delayed 3 cycles.
- post_frame_de  out  1  DE delayed 3 cycles.
- img_y / img_cb / img_cr  out  DW  output components, unsigned.
- mode_act  out  1  coefficient mode currently in force.

## Operation
- Coefficients are Q8 (scale 256), signed 9-bit. BT.601: Y 77,150,29; Cb -43,-85,128; Cr 128,-107,-21. BT.709: Y 54,183,19; Cb -29,-99,128; Cr 128,-116,-12.
- Per channel: acc = cR·R + cG·G + cB·B + OFS + 128; out = acc >>> 8, clamped to [0, 2^DW-1]. OFS = 0 for Y, 2^(DW-1)·256 for Cb/Cr. Accumulator signed, DW+11 bits; no intermediate overflow permitted.
- Mode register: loaded with mode_sel on the rising edge of pre_frame_vsync (registered previous vsync = 0, current = 1); holds otherwise. Coefficients used for a pixel are those of mode_act at the cycle the pixel enters stage 1. Mid-frame changes of mode_sel have no effect until the next vsync rise.
- Output gating: img_y/cb/cr are forced to 0 in any cycle where post_frame_de = 0.
- Pipeline runs every cycle (no stall, no backpressure); data enters regardless of DE.

## Timing
- Stage 1: nine products registered. Stage 2: three sums + offset + rounding constant registered. Stage 3: shift, clamp, DE gating registered to outputs.
- Latency exactly 3 cycles from inputs to all outputs; vsync/hsync/de delay lines are 3 flops each and stay aligned with data.
- Throughput 1 pixel/cycle.
- Reset: all pipeline registers, delay lines and outputs go to 0 immediately on rst; mode_act = MODE_RST. After rst deasserts, outputs remain 0 for 3 cycles regardless of input.
- Reset mid-frame: in-flight pixels are discarded; no partial line is flushed.
- Vsync rise coincident with a mode_sel change: the new value is taken.

## Structure
- Package rgb2ycbcr_pkg: mode enum (MODE_601, MODE_709), the two 3×3 Q8 coefficient constant sets, frac-bits constant (8).
- Sub-module ycc_dot3: one channel's 3-stage dot-product/offset/round/clamp pipeline, parametrised by DW and offset select; instantiated three times. Top holds the mode register, coefficient mux and sync delay lines.

## Test plan
- DW=8, mode 601, DE=1, RGB (255,255,255) -> after exactly 3 cycles Y=255, Cb=128, Cr=128; (0,0,0) -> 0,128,128.
- DW=8, mode 601, RGB (255,0,0) -> Y=77, Cb=85, Cr=255 (saturated from 256); (0,0,255) -> Cb=255 saturated.
- DW=8, mode 709 (set before vsync rise), RGB (255,0,0) -> Y=54, Cb=99, Cr=255; toggle mode_sel mid-frame -> results unchanged until next vsync rise, mode_act then flips.
- DW=10, mode 601, RGB (1023,1023,1023) -> Y=1023, Cb=512, Cr=512; (0,0,0) -> 0,512,512.
- Random pixel stream with DE/hsync/vsync pattern -> outputs match a rounding/clamping reference model, syncs delayed exactly 3 cycles, img_* = 0 whenever post_frame_de = 0.
- Assert rst mid-line -> all outputs 0 in the same cycle, mode_act = MODE_RST; after release, first valid output appears 3 cycles after first DE=1 input.
